// File: rtl/tx_frame_ser_pkg.sv
// Shared constants and FSM encoding for the TX frame serialiser.
package tx_frame_ser_pkg;

    localparam int unsigned DATA_LENGTH = 32;
    localparam int unsigned CRC_LENGTH  = 10;
    localparam int unsigned CNT_WIDTH   = 6;
    localparam logic [CRC_LENGTH-1:0] CRC_POLY = 10'h233;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCrcWait = 2'd1,
        StShift   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/tx_ser_shift.sv
// Parallel-load, ready-gated MSB-first shift register with bit counter and frame markers.
module tx_ser_shift
    import tx_frame_ser_pkg::*;
#(
    parameter int unsigned FRAME_W = DATA_LENGTH + CRC_LENGTH,
    parameter int unsigned CNT_W   = CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               ser_rdy,
    output logic               ser_o,
    output logic               ser_vld,
    output logic               sof,
    output logic               eof,
    output logic               last
);

    logic [FRAME_W-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               vld_q;
    logic               sof_q;
    logic               eof_q;
    logic               consume;

    assign consume = vld_q & ser_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load) begin
            shreg_q <= load_data;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
            sof_q   <= 1'b1;
            eof_q   <= 1'b0;
        end else if (consume) begin
            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
            cnt_q   <= cnt_q + 1'b1;
            sof_q   <= 1'b0;
            // Markers are flopped one bit ahead so they line up with the presented bit.
            eof_q   <= (cnt_q == CNT_W'(FRAME_W - 2));
            if (eof_q) begin
                vld_q <= 1'b0;
                eof_q <= 1'b0;
            end
        end
    end

    assign ser_o   = shreg_q[FRAME_W-1];
    assign ser_vld = vld_q;
    assign sof     = sof_q;
    assign eof     = eof_q;
    assign last    = consume & eof_q;

endmodule

// File: rtl/tx_frame_ser.sv
// TX frame serialiser: accepts a payload, waits for its CRC, then emits {payload, crc} bit-serially.
module tx_frame_ser
    import tx_frame_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_LENGTH,
    parameter int unsigned CRC_W  = CRC_LENGTH,
    parameter int unsigned CNT_W  = CNT_WIDTH,
    parameter int unsigned TO_CYC = DATA_W + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_vld,
    output logic              data_rdy,
    output logic              crc_start,
    output logic [DATA_W-1:0] crc_data_o,
    input  logic              crc_vld,
    input  logic [CRC_W-1:0]  crc_i,
    input  logic              ser_rdy,
    output logic              ser_o,
    output logic              ser_vld,
    output logic              sof,
    output logic              eof,
    output logic              crc_err
);

    localparam int unsigned FRAME_W = DATA_W + CRC_W;
    localparam int unsigned TO_W    = $clog2(TO_CYC + 1);

    tx_state_e         state_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [DATA_W-1:0] payload_q;
    logic              data_rdy_q;
    logic              crc_start_q;
    logic              crc_err_q;
    logic              load;
    logic              frame_done;

    // The CRC result goes straight into the shifter on its valid cycle.
    assign load = (state_q == StCrcWait) && crc_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            to_cnt_q    <= '0;
            payload_q   <= '0;
            data_rdy_q  <= 1'b1;
            crc_start_q <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            crc_start_q <= 1'b0;
            crc_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (data_vld && data_rdy_q) begin
                        payload_q   <= data_i;
                        crc_start_q <= 1'b1;
                        data_rdy_q  <= 1'b0;
                        to_cnt_q    <= '0;
                        state_q     <= StCrcWait;
                    end
                end
                StCrcWait: begin
                    if (crc_vld) begin
                        state_q <= StShift;
                    end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                        crc_err_q  <= 1'b1;
                        data_rdy_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (frame_done) begin
                        data_rdy_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    tx_ser_shift #(
        .FRAME_W (FRAME_W),
        .CNT_W   (CNT_W)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data ({payload_q, crc_i}),
        .ser_rdy   (ser_rdy),
        .ser_o     (ser_o),
        .ser_vld   (ser_vld),
        .sof       (sof),
        .eof       (eof),
        .last      (frame_done)
    );

    assign data_rdy   = data_rdy_q;
    assign crc_start  = crc_start_q;
    assign crc_data_o = payload_q;
    assign crc_err    = crc_err_q;

endmodule

// File: doc/tx_frame_ser.md
Name: tx_frame_ser

Overview:
- Downstream stage of the TX CRC generator in the SerDes TX datapath.
- Accepts a parallel data word from the upstream source, launches the CRC engine and waits for its result.
- Serialises the frame MSB-first at one bit per accepted cycle toward the line driver: DATA_W data bits followed by CRC_W CRC bits.
- Supports downstream backpressure and a CRC-timeout error.

Parameters:
- DATA_W, `DATA_LENGTH (32): payload width in bits.
- CRC_W, `CRC_LENGTH (10): CRC width in bits.
- CNT_W, 6: bit-counter width; must satisfy 2^CNT_W > DATA_W+CRC_W.
- TO_CYC, DATA_W+4: CRC-wait timeout in cycles.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: synchronous, active-low reset.
- data_i, input, DATA_W: payload word.
- data_vld, input, 1: payload valid.
- data_rdy, output, 1: block ready to accept payload.
- crc_start, output, 1: one-cycle start pulse to the CRC engine.
- crc_data_o, output, DATA_W: payload driven to the CRC engine.
- crc_vld, input, 1: CRC engine result-valid pulse.
- crc_i, input, CRC_W: CRC engine result.
- ser_rdy, input, 1: downstream accepts a bit this cycle.
- ser_o, output, 1: serial bit.
- ser_vld, output, 1: ser_o is valid.
- sof, output, 1: high with the first frame bit.
- eof, output, 1: high with the last frame bit.
- crc_err, output, 1: one-cycle pulse on CRC timeout.

Behaviour:
- Reset (rst_n low at a clk edge, synchronous):
  - State = IDLE.
  - data_rdy=1; crc_start, ser_o, ser_vld, sof, eof, crc_err = 0; crc_data_o = 0.
  - Bit counter = 0, timeout counter = 0, shift register = 0.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion.
- FSM states: IDLE, CRC_WAIT, SHIFT.
- IDLE:
  - data_rdy=1.
  - On data_vld&data_rdy: latch data_i into the payload register and crc_data_o.
  - crc_start=1 for exactly the next cycle; go to CRC_WAIT.
  - data_rdy=0 from the cycle after acceptance until return to IDLE.
- CRC_WAIT:
  - Timeout counter increments every cycle.
  - On crc_vld=1: latch crc_i; load the shift register with {payload, crc_i}; bit counter=0; go to SHIFT.
  - The CRC is captured only on the crc_vld cycle. The block does not depend on the CRC engine's fixed latency.
  - If the counter reaches TO_CYC-1 without crc_vld: crc_err=1 for one cycle, frame discarded, return to IDLE.
  - If crc_vld arrives in the same cycle the counter reaches TO_CYC-1, crc_vld wins: no error, proceed to SHIFT.
- SHIFT:
  - ser_vld=1 continuously; ser_o = shift-register MSB.
  - A bit is consumed only on a cycle with ser_vld&ser_rdy. On consumption: shift left by one and increment the bit counter.
  - ser_rdy=0 holds ser_o, sof and eof stable (no bit lost or duplicated).
  - sof=1 while bit counter==0; eof=1 while bit counter==DATA_W+CRC_W-1.
  - On consumption of the eof bit: ser_vld=0 next cycle, return to IDLE, data_rdy=1 next cycle.
- Throughput:
  - Minimum frame-to-frame gap is one IDLE cycle.
  - Back-to-back data_vld is held off by data_rdy=0.
- Stray inputs:
  - crc_vld in IDLE or SHIFT is ignored.
  - data_vld outside IDLE is ignored; no acceptance.
- All outputs are registered. Latency from the crc_vld cycle to the first ser_vld cycle is 1 cycle.

Decomposition:
- Shared package/include (para.v): DATA_LENGTH, CRC_LENGTH, CNT_WIDTH, CRC_POLY, and the FSM state encodings (2-bit: IDLE=0, CRC_WAIT=1, SHIFT=2).
- One natural sub-module: tx_ser_shift, a parallel-load, ser_rdy-gated shift register with bit counter, sof and eof generation.
- The FSM and timeout logic stay in the top.

Test Plan:
- Nominal frame: data_i=32'hA5A5_0001, ser_rdy=1, CRC model returns crc_vld after 33 cycles with 10'h2F3.
  - Expect crc_start for one cycle, then 42 serial bits equal to {32'hA5A5_0001, 10'h2F3} MSB-first.
  - sof on bit 0, eof on bit 41, data_rdy=1 the cycle after eof.
- Backpressure: same frame with ser_rdy toggling 1,0,0,1 repeatedly.
  - Output bit sequence identical to the nominal case; ser_o stable during ser_rdy=0; eof only on the last bit.
- Timeout: crc_vld never asserted.
  - crc_err pulses once exactly TO_CYC=36 cycles after entering CRC_WAIT; no ser_vld; data_rdy=1 the next cycle.
- Timeout tie: crc_vld asserted in the same cycle as the timeout terminal count.
  - No crc_err; full 42-bit frame emitted.
- Reset mid-SHIFT: rst_n=0 for one edge at bit 20.
  - Next cycle ser_vld=0, sof=eof=0, data_rdy=1.
  - A new frame afterwards serialises correctly from bit 0.
- Back-to-back: data_vld held high with two words.
  - Second word accepted only in the IDLE cycle after the first frame's eof; crc_vld pulses during SHIFT are ignored.
